// File: rtl/gas_pkg.sv
// Shared definitions for the gas-sensor sequence detector:
// channel limits, detect-mode encodings and default patterns.
package gas_pkg;

    // Upper bound on channels; cfg_ch is 3 bits wide.
    localparam int GAS_MAX_CH = 8;

    // Widest pattern supported; defaults are stored this wide.
    localparam int GAS_PAT_W = 8;

    // Detect mode of a channel.
    typedef enum logic {
        GAS_MODE_NONOVL = 1'b0,
        GAS_MODE_OVL    = 1'b1
    } gas_mode_e;

    // Reset-time pattern of channel ch, right-aligned.
    // A channel of PAT_LEN bits takes the low PAT_LEN bits.
    function automatic logic [GAS_PAT_W-1:0] gas_def_pat(
        input int ch
    );
        logic [GAS_PAT_W-1:0] v;
        v = '0;
        case (ch)
            0:       v = 8'b0000_1011;
            1:       v = 8'b0000_0110;
            2:       v = 8'b0000_1111;
            3:       v = 8'b0000_1001;
            4:       v = 8'b0000_0101;
            5:       v = 8'b0000_1110;
            6:       v = 8'b0000_0011;
            7:       v = 8'b0000_1101;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/gas_seq_channel.sv
// One detector channel: bit history, fill counter, pattern/mode,
// saturating hit counter and sticky alarm.
//
// Ports:
//   clk, arst      clock, synchronous active-high reset
//   i_din          serial data bit
//   i_din_valid    i_din is sampled when high
//   i_cfg_we       write strobe for this channel
//   i_cfg_pat      new pattern, MSB = oldest bit
//   i_cfg_ovl      new mode, 1 = overlapping
//   i_alarm_clr    clear hit counter and alarm
//   o_dout         one-cycle detect pulse
//   o_alarm        sticky alarm
//   o_hit_cnt      saturating hit count
module gas_seq_channel
    import gas_pkg::*;
#(
    parameter int PAT_LEN  = 4,
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 4,
    parameter logic [PAT_LEN-1:0] DEF_PAT = '0
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               i_din,
    input  logic               i_din_valid,
    input  logic               i_cfg_we,
    input  logic [PAT_LEN-1:0] i_cfg_pat,
    input  logic               i_cfg_ovl,
    input  logic               i_alarm_clr,
    output logic               o_dout,
    output logic               o_alarm,
    output logic [CNT_W-1:0]   o_hit_cnt
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);

    localparam logic [FILL_W-1:0] FILL_FULL =
        FILL_W'(PAT_LEN);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [CNT_W-1:0] CNT_TH =
        CNT_W'(ALARM_TH);

    // Only the newest PAT_LEN-1 bits are kept: the oldest
    // bit of a full history is shifted out on the very
    // update that would compare against it, so the updated
    // PAT_LEN-bit history is {r_hist, i_din}.
    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [PAT_LEN-1:0] r_pat;
    gas_mode_e          r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_alarm;
    logic               r_dout;

    logic [PAT_LEN-1:0] w_hist_nxt;
    logic [FILL_W-1:0]  w_fill_inc;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic               w_match;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_alarm_nxt;

    always_comb begin
        w_hist_nxt = {r_hist, i_din};

        w_fill_inc = r_fill;
        if (r_fill != FILL_FULL) begin
            w_fill_inc = r_fill + FILL_W'(1);
        end

        // A write cycle never matches: the old pattern is
        // being replaced and the fill restarts.
        w_match = i_din_valid
               && !i_cfg_we
               && (w_hist_nxt == r_pat)
               && (w_fill_inc == FILL_FULL);

        w_fill_nxt = r_fill;
        if (i_cfg_we) begin
            w_fill_nxt = '0;
        end else if (w_match &&
                     r_mode == GAS_MODE_NONOVL) begin
            w_fill_nxt = '0;
        end else if (i_din_valid) begin
            w_fill_nxt = w_fill_inc;
        end

        // Clear beats a coincident hit.
        w_cnt_nxt = r_cnt;
        if (i_alarm_clr) begin
            w_cnt_nxt = '0;
        end else if (w_match && r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        // Alarm follows the registered count one cycle late.
        w_alarm_nxt = 1'b0;
        if (!i_alarm_clr) begin
            w_alarm_nxt = r_alarm || (r_cnt >= CNT_TH);
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= DEF_PAT;
            r_mode  <= GAS_MODE_OVL;
            r_cnt   <= '0;
            r_alarm <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            if (i_din_valid) begin
                r_hist <= w_hist_nxt[PAT_LEN-2:0];
            end
            if (i_cfg_we) begin
                r_pat  <= i_cfg_pat;
                r_mode <= gas_mode_e'(i_cfg_ovl);
            end
            r_fill  <= w_fill_nxt;
            r_cnt   <= w_cnt_nxt;
            r_alarm <= w_alarm_nxt;
            r_dout  <= w_match;
        end
    end

    assign o_dout    = r_dout;
    assign o_alarm   = r_alarm;
    assign o_hit_cnt = r_cnt;

endmodule

// File: rtl/gas_seq_detector.sv
// Multi-channel serial pattern detector for gas-sensor data.
// All channels watch the same din stream independently.
//
// Ports:
//   clk, arst   clock, synchronous active-high reset
//   din         serial data bit
//   din_valid   din is sampled when high
//   cfg_we      pattern/mode write strobe
//   cfg_ch      target channel; >= NUM_CH is ignored
//   cfg_pat     new pattern, MSB = oldest bit
//   cfg_ovl     new mode, 1 = overlapping
//   alarm_clr   per-channel counter/alarm clear
//   dout        per-channel one-cycle detect pulse
//   alarm       per-channel sticky alarm
//   hit_cnt     channel k at [k*CNT_W +: CNT_W]
module gas_seq_detector
    import gas_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int PAT_LEN  = 4,
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 4
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    din,
    input  logic                    din_valid,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_ch,
    input  logic [PAT_LEN-1:0]      cfg_pat,
    input  logic                    cfg_ovl,
    input  logic [NUM_CH-1:0]       alarm_clr,
    output logic [NUM_CH-1:0]       dout,
    output logic [NUM_CH-1:0]       alarm,
    output logic [NUM_CH*CNT_W-1:0] hit_cnt
);

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            localparam logic [GAS_PAT_W-1:0] W_DEF =
                gas_def_pat(k);

            logic w_sel;

            assign w_sel = cfg_we && (cfg_ch == 3'(k));

            gas_seq_channel #(
                .PAT_LEN  (PAT_LEN),
                .CNT_W    (CNT_W),
                .ALARM_TH (ALARM_TH),
                .DEF_PAT  (W_DEF[PAT_LEN-1:0])
            ) u_ch (
                .clk         (clk),
                .arst        (arst),
                .i_din       (din),
                .i_din_valid (din_valid),
                .i_cfg_we    (w_sel),
                .i_cfg_pat   (cfg_pat),
                .i_cfg_ovl   (cfg_ovl),
                .i_alarm_clr (alarm_clr[k]),
                .o_dout      (dout[k]),
                .o_alarm     (alarm[k]),
                .o_hit_cnt   (hit_cnt[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gas_seq_detector.sv
// Bench for gas_seq_detector: directed scenarios with literal
// expectations plus random traffic against a queue-based model.
module tb_gas_seq_detector;

    localparam int TH_A  = 4;
    localparam int MAX_A = 255;
    localparam int TH_B  = 2;
    localparam int MAX_B = 3;

    localparam logic [3:0] DEF [3] =
        '{4'b1011, 4'b0110, 4'b1111};

    logic        clk;
    logic        arst;
    logic        din;
    logic        din_valid;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [3:0]  cfg_pat;
    logic        cfg_ovl;
    logic [2:0]  alarm_clr;
    logic [2:0]  douta, alarma;
    logic [23:0] hita;
    logic [2:0]  doutb, alarmb;
    logic [5:0]  hitb;

    int checks = 0;
    int errors = 0;

    gas_seq_detector #(
        .NUM_CH(3), .PAT_LEN(4), .CNT_W(8), .ALARM_TH(TH_A)
    ) u_dut_a (
        .clk(clk), .arst(arst), .din(din),
        .din_valid(din_valid), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_pat(cfg_pat),
        .cfg_ovl(cfg_ovl), .alarm_clr(alarm_clr),
        .dout(douta), .alarm(alarma), .hit_cnt(hita)
    );

    gas_seq_detector #(
        .NUM_CH(3), .PAT_LEN(4), .CNT_W(2), .ALARM_TH(TH_B)
    ) u_dut_b (
        .clk(clk), .arst(arst), .din(din),
        .din_valid(din_valid), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_pat(cfg_pat),
        .cfg_ovl(cfg_ovl), .alarm_clr(alarm_clr),
        .dout(doutb), .alarm(alarmb), .hit_cnt(hitb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: per channel, the valid bits seen since the last
    // fill restart (reset, write, non-overlapping hit).
    bit         mq [3][$];
    logic [3:0] mpat [3];
    bit         movl [3];
    int         mca [3];
    int         mcb [3];
    bit         mala [3];
    bit         malb [3];
    bit         mdout [3];

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            bit         sel;
            bit         hit;
            logic [3:0] w;
            sel = cfg_we && (cfg_ch == 3'(c));
            hit = 1'b0;
            if (arst) begin
                mq[c].delete();
                mpat[c] = DEF[c];
                movl[c] = 1'b1;
                mca[c] = 0;
                mcb[c] = 0;
                mala[c] = 1'b0;
                malb[c] = 1'b0;
            end else begin
                mala[c] = !alarm_clr[c] &&
                          (mala[c] || mca[c] >= TH_A);
                malb[c] = !alarm_clr[c] &&
                          (malb[c] || mcb[c] >= TH_B);
                if (din_valid) begin
                    mq[c].push_back(din);
                    if (mq[c].size() > 4)
                        void'(mq[c].pop_front());
                    if (!sel && mq[c].size() == 4) begin
                        w = {mq[c][0], mq[c][1],
                             mq[c][2], mq[c][3]};
                        if (w == mpat[c]) begin
                            hit = 1'b1;
                            if (!movl[c]) mq[c].delete();
                        end
                    end
                end
                if (sel) begin
                    mq[c].delete();
                    mpat[c] = cfg_pat;
                    movl[c] = cfg_ovl;
                end
                if (alarm_clr[c]) begin
                    mca[c] = 0;
                    mcb[c] = 0;
                end else if (hit) begin
                    if (mca[c] < MAX_A) mca[c]++;
                    if (mcb[c] < MAX_B) mcb[c]++;
                end
            end
            mdout[c] = hit;
        end
    endtask

    always @(posedge clk) begin
        logic [2:0]  ed, eaa, eab;
        logic [23:0] eha;
        logic [5:0]  ehb;
        model_step();
        #1;
        for (int c = 0; c < 3; c++) begin
            ed[c]  = mdout[c];
            eaa[c] = mala[c];
            eab[c] = malb[c];
            eha[c*8 +: 8] = 8'(mca[c]);
            ehb[c*2 +: 2] = 2'(mcb[c]);
        end
        chk("m_dout_a",  32'(douta),  32'(ed));
        chk("m_alarm_a", 32'(alarma), 32'(eaa));
        chk("m_hit_a",   32'(hita),   32'(eha));
        chk("m_dout_b",  32'(doutb),  32'(ed));
        chk("m_alarm_b", 32'(alarmb), 32'(eab));
        chk("m_hit_b",   32'(hitb),   32'(ehb));
    end

    logic [2:0] obs [64];

    task automatic quiet();
        din_valid = 1'b0;
        cfg_we    = 1'b0;
        alarm_clr = '0;
        arst      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            quiet();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        quiet();
        arst = 1'b1;
        @(posedge clk);
        #2;
    endtask

    // Sends n bits MSB first; obs[i] = dout after bit i.
    task automatic send_bits(input logic [63:0] bits,
                             input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            quiet();
            din = bits[n-1-i];
            din_valid = 1'b1;
            @(posedge clk);
            #2;
            obs[i] = douta;
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic cfg_write(input logic [2:0] ch,
                             input logic [3:0] pat,
                             input logic ovl);
        @(negedge clk);
        quiet();
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_pat = pat;
        cfg_ovl = ovl;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] mask(input int c,
                                         input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = obs[i][c];
        return m;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        din = 1'b0;
        din_valid = 1'b0;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_pat = '0;
        cfg_ovl = 1'b0;
        alarm_clr = '0;
        @(posedge clk);
        #2;
        chk("rst_dout",  32'(douta),  0);
        chk("rst_alarm", 32'(alarma), 0);
        chk("rst_hit",   32'(hita),   0);

        // 1011 -> ch0 only, after the 4th bit
        send_bits(64'b1011, 4, 0);
        chk("d1_pre",  32'({obs[0], obs[1], obs[2]}), 0);
        chk("d1_dout", 32'(obs[3]), 32'b001);
        chk("d1_hit0", 32'(hita[7:0]), 1);

        // ch2 overlapping, then non-overlapping
        do_reset();
        send_bits(64'b111111, 6, 0);
        chk("d2_ovl", 32'(mask(2, 6)), 32'b111000);
        chk("d2_hit2", 32'(hita[23:16]), 3);
        cfg_write(3'd2, 4'b1111, 1'b0);
        send_bits(64'hFF, 8, 0);
        chk("d2_nov", 32'(mask(2, 8)), 32'b1000_1000);

        // four hits -> alarm; clear beats 5th hit
        do_reset();
        send_bits(64'hBBBB, 16, 0);
        chk("d3_hits", 32'(mask(0, 16)), 32'h8888);
        idle(1);
        chk("d3_alarm", 32'(alarma[0]), 1);
        send_bits(64'b101, 3, 0);
        @(negedge clk);
        quiet();
        din = 1'b1;
        din_valid = 1'b1;
        alarm_clr = 3'b001;
        @(posedge clk);
        #2;
        chk("d3_clr_dout",  32'(douta[0]), 1);
        chk("d3_clr_hit",   32'(hita[7:0]), 0);
        chk("d3_clr_alarm", 32'(alarma[0]), 0);

        // narrow counter saturates
        do_reset();
        send_bits(64'hBBBBBB, 24, 0);
        chk("d4_sat_b", 32'(hitb[1:0]), 3);
        chk("d4_cnt_a", 32'(hita[7:0]), 6);

        // rewrite ch1 mid-pattern
        do_reset();
        send_bits(64'b10, 2, 0);
        cfg_write(3'd1, 4'b1011, 1'b1);
        send_bits(64'b1011, 4, 0);
        chk("d5_pre",
            32'({obs[0], obs[1], obs[2]}), 0);
        chk("d5_dout", 32'(obs[3]), 32'b011);

        // reset mid-pattern, without and with gaps
        for (int g = 0; g <= 2; g += 2) begin
            do_reset();
            send_bits(64'b101, 3, g);
            do_reset();
            send_bits(64'b1, 1, g);
            chk("d6_none", 32'(obs[0]), 0);
            send_bits(64'b1011, 4, g);
            chk("d6_one", 32'(mask(0, 4)), 32'b1000);
        end

        // random traffic, model-checked every cycle
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            arst      = ($urandom_range(0, 249) == 0);
            din       = 1'($urandom);
            din_valid = ($urandom_range(0, 9) < 7);
            cfg_we    = ($urandom_range(0, 39) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_pat   = 4'($urandom);
            cfg_ovl   = 1'($urandom);
            alarm_clr = '0;
            if ($urandom_range(0, 49) == 0)
                alarm_clr = 3'($urandom);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
